// File: rtl/hdmi_pkg.sv
// Shared types, fixed lengths and the BCH step used by the HDMI data-island generator.
package hdmi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StGbl,
    StData,
    StGbt
  } state_e;

  localparam int unsigned PRE_LEN     = 8;
  localparam int unsigned GB_LEN      = 2;
  localparam int unsigned DATA_LEN    = 32;
  localparam int unsigned MAX_PKTS    = 18;
  localparam int unsigned HDR_BITS    = 24;
  localparam int unsigned SUB_BEATS   = 28;
  localparam logic [7:0]  ECC_POLY    = 8'h83;
  localparam logic [3:0]  PREAMBLE_DI = 4'b0101;

  // One LSB-first step of the x^8+x^7+x^6+1 BCH code.
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    logic [7:0] nxt;
    nxt = ecc >> 1;
    if (ecc[0] ^ b) nxt = nxt ^ ECC_POLY;
    return nxt;
  endfunction

endpackage

// File: rtl/hdmi_data_island_if.sv
// Packet handshake between the packet source and the data-island generator.
interface hdmi_data_island_if;
  logic         PKT_VALID;
  logic         PKT_READY;
  logic [23:0]  PKT_HB;
  logic [223:0] PKT_PB;

  modport master (output PKT_VALID, output PKT_HB, output PKT_PB, input PKT_READY);
  modport slave  (input PKT_VALID, input PKT_HB, input PKT_PB, output PKT_READY);
endinterface

// File: rtl/hdmi_bch_ecc.sv
// BCH ECC accumulator: 1 or 2 bits per step, optional clear, and right-shift during emission.
module hdmi_bch_ecc
  import hdmi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       step_i,
  input  logic       shift_i,
  input  logic       two_i,
  input  logic [1:0] bits_i,
  output logic [7:0] ecc_o
);

  logic [7:0] ecc_q, ecc_d;
  logic [7:0] base, one;

  // Clear folds into the same cycle so a freshly accepted packet can step immediately.
  always_comb begin
    base  = clr_i ? 8'h00 : ecc_q;
    one   = bch_step(base, bits_i[0]);
    ecc_d = base;
    if (step_i) begin
      ecc_d = two_i ? bch_step(one, bits_i[1]) : one;
    end else if (shift_i) begin
      ecc_d = two_i ? (base >> 2) : (base >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ecc_q <= 8'h00;
    else         ecc_q <= ecc_d;
  end

  assign ecc_o = ecc_q;

endmodule

// File: rtl/hdmi_data_island.sv
// HDMI data-island sequencer: preamble, guard bands, 32 TERC4 data cycles with BCH ECC.
// Define HDMI_DI_MULTI_PKT_EN to allow up to MAX_PKTS back-to-back packets per island.
module hdmi_data_island
  import hdmi_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               HSYNC,
  input  logic               VSYNC,
  hdmi_data_island_if.slave  pkt,
  output logic               PREAMBLE,
  output logic [3:0]         CTL,
  output logic               GUARD,
  output logic               ADE,
  output logic [3:0]         AUX0,
  output logic [3:0]         AUX1,
  output logic [3:0]         AUX2,
  output logic               BUSY
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              accept_idle, accept_data, accept;
  logic [23:0]       hdr_q, hdr_d, hdr_src;
  logic [3:0][55:0]  pb_q, pb_d, pb_src;
  logic              hdr_bit, hdr_step, hdr_shift, sub_step, sub_shift;
  logic [3:0][1:0]   sub_bits;
  logic [7:0]        hdr_ecc;
  logic [3:0][7:0]   sub_ecc;

  logic              preamble_q, preamble_d, guard_q, guard_d, ade_q, ade_d, busy_q, busy_d;
  logic [3:0]        ctl_q, ctl_d, aux0_q, aux0_d, aux1_q, aux1_d, aux2_q, aux2_d;

  assign accept_idle   = (state_q == StIdle) && START && pkt.PKT_VALID;
  assign accept        = accept_idle || accept_data;
  assign pkt.PKT_READY = accept;

`ifdef HDMI_DI_MULTI_PKT_EN
  logic [4:0] pkt_cnt_q, pkt_cnt_d;

  assign accept_data = (state_q == StData) && (cnt_q == 5'(DATA_LEN - 1)) && pkt.PKT_VALID &&
                       (pkt_cnt_q < 5'(MAX_PKTS));

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (accept_idle)      pkt_cnt_d = 5'd1;
    else if (accept_data) pkt_cnt_d = pkt_cnt_q + 5'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pkt_cnt_q <= 5'd0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end
`else
  assign accept_data = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    unique case (state_q)
      StIdle: begin
        cnt_d = 5'd0;
        if (accept_idle) state_d = StPre;
      end
      StPre: if (cnt_q == 5'(PRE_LEN - 1)) begin
        state_d = StGbl;
        cnt_d   = 5'd0;
      end
      StGbl: if (cnt_q == 5'(GB_LEN - 1)) begin
        state_d = StData;
        cnt_d   = 5'd0;
      end
      StData: if (cnt_q == 5'(DATA_LEN - 1)) begin
        state_d = accept_data ? StData : StGbt;
        cnt_d   = 5'd0;
      end
      StGbt: if (cnt_q == 5'(GB_LEN - 1)) begin
        state_d = StIdle;
        cnt_d   = 5'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Outputs are registered, so data for cycle k is produced while moving into it (state_d/cnt_d).
  always_comb begin
    hdr_src   = accept ? pkt.PKT_HB : hdr_q;
    hdr_d     = hdr_src;
    hdr_bit   = 1'b0;
    hdr_step  = 1'b0;
    hdr_shift = 1'b0;
    sub_step  = 1'b0;
    sub_shift = 1'b0;
    sub_bits  = '0;
    for (int i = 0; i < 4; i++) begin
      pb_src[i] = accept ? pkt.PKT_PB[56*i +: 56] : pb_q[i];
    end
    pb_d = pb_src;
    if (state_d == StData) begin
      if (cnt_d < 5'(HDR_BITS)) begin
        hdr_bit  = hdr_src[0];
        hdr_d    = hdr_src >> 1;
        hdr_step = 1'b1;
      end else begin
        hdr_bit   = hdr_ecc[0];
        hdr_shift = 1'b1;
      end
      sub_step  = (cnt_d < 5'(SUB_BEATS));
      sub_shift = !sub_step;
      for (int i = 0; i < 4; i++) begin
        if (sub_step) begin
          sub_bits[i] = pb_src[i][1:0];
          pb_d[i]     = pb_src[i] >> 2;
        end else begin
          sub_bits[i] = sub_ecc[i][1:0];
        end
      end
    end
  end

  hdmi_bch_ecc u_hdr_ecc (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (accept),
    .step_i  (hdr_step),
    .shift_i (hdr_shift),
    .two_i   (1'b0),
    .bits_i  ({1'b0, hdr_bit}),
    .ecc_o   (hdr_ecc)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sub_ecc
    hdmi_bch_ecc u_sub_ecc (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .clr_i   (accept),
      .step_i  (sub_step),
      .shift_i (sub_shift),
      .two_i   (1'b1),
      .bits_i  (sub_bits[g]),
      .ecc_o   (sub_ecc[g])
    );
  end

  always_comb begin
    preamble_d = 1'b0;
    ctl_d      = 4'h0;
    guard_d    = 1'b0;
    ade_d      = 1'b0;
    aux0_d     = 4'h0;
    aux1_d     = 4'h0;
    aux2_d     = 4'h0;
    busy_d     = (state_d != StIdle);
    unique case (state_d)
      StPre: begin
        preamble_d = 1'b1;
        ctl_d      = PREAMBLE_DI;
      end
      StGbl, StGbt: begin
        guard_d = 1'b1;
        aux0_d  = {2'b11, VSYNC, HSYNC};
      end
      StData: begin
        ade_d  = 1'b1;
        aux0_d = {cnt_d != 5'd0, hdr_bit, VSYNC, HSYNC};
        for (int i = 0; i < 4; i++) begin
          aux1_d[i] = sub_bits[i][0];
          aux2_d[i] = sub_bits[i][1];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      hdr_q      <= '0;
      pb_q       <= '0;
      preamble_q <= 1'b0;
      ctl_q      <= 4'h0;
      guard_q    <= 1'b0;
      ade_q      <= 1'b0;
      aux0_q     <= 4'h0;
      aux1_q     <= 4'h0;
      aux2_q     <= 4'h0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      pb_q       <= pb_d;
      preamble_q <= preamble_d;
      ctl_q      <= ctl_d;
      guard_q    <= guard_d;
      ade_q      <= ade_d;
      aux0_q     <= aux0_d;
      aux1_q     <= aux1_d;
      aux2_q     <= aux2_d;
      busy_q     <= busy_d;
    end
  end

  assign PREAMBLE = preamble_q;
  assign CTL      = ctl_q;
  assign GUARD    = guard_q;
  assign ADE      = ade_q;
  assign AUX0     = aux0_q;
  assign AUX1     = aux1_q;
  assign AUX2     = aux2_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_hdmi_data_island.sv
// Randomized bench for hdmi_data_island against a timeline/bit-vector reference model.
module tb_hdmi_data_island;

  logic       clk = 1'b0;
  logic       rst_n, start, hsync, vsync;
  logic       preamble, guard, ade, busy;
  logic [3:0] ctl, aux0, aux1, aux2;
  logic [19:0] obs;
  int n_checks = 0;
  int n_errors = 0;

`ifdef HDMI_DI_MULTI_PKT_EN
  localparam bit HoldOk  = 1'b0;
  localparam int ExpPkts = 18;
`else
  localparam bit HoldOk  = 1'b1;
  localparam int ExpPkts = 1;
`endif

  hdmi_data_island_if pkt_if();

  hdmi_data_island dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .START    (start),
    .HSYNC    (hsync),
    .VSYNC    (vsync),
    .pkt      (pkt_if),
    .PREAMBLE (preamble),
    .CTL      (ctl),
    .GUARD    (guard),
    .ADE      (ade),
    .AUX0     (aux0),
    .AUX1     (aux1),
    .AUX2     (aux2),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  assign obs = {preamble, ctl, guard, ade, aux0, aux1, aux2, busy};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bch(input logic [63:0] d, input int n);
    logic [7:0] e;
    logic fb;
    e = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = e[0] ^ d[i];
      e  = e >> 1;
      if (fb) e = e ^ 8'h83;
    end
    return e;
  endfunction

  // Expected output bundle j cycles after the accept cycle.
  function automatic logic [19:0] exp_out(input int j, input logic [31:0] hb,
                                          input logic [3:0][63:0] sb, input logic hs,
                                          input logic vs);
    logic pre, gd, ad, bz;
    logic [3:0] c, a0, a1, a2;
    int k;
    {pre, gd, ad, bz} = 4'b0;
    {c, a0, a1, a2} = 16'h0;
    bz = (j >= 1 && j <= 44);
    if (j >= 1 && j <= 8) begin
      pre = 1'b1;
      c   = 4'b0101;
    end else if (j == 9 || j == 10 || j == 43 || j == 44) begin
      gd = 1'b1;
      a0 = {2'b11, vs, hs};
    end else if (j >= 11 && j <= 42) begin
      k  = j - 11;
      ad = 1'b1;
      a0 = {k != 0, hb[k], vs, hs};
      for (int i = 0; i < 4; i++) begin
        a1[i] = sb[i][2*k];
        a2[i] = sb[i][2*k+1];
      end
    end
    return {pre, c, gd, ad, a0, a1, a2, bz};
  endfunction

  task automatic rand_pb(output logic [223:0] pb);
    for (int w = 0; w < 7; w++) pb[32*w +: 32] = $urandom();
  endtask

  // Drive an accept in the current cycle, then check cycles 1..stop_j after it.
  task automatic island(input logic [23:0] hb, input logic [223:0] pb, input bit hold,
                        input bit poke, input bit rsync, input int stop_j);
    logic [31:0]      hbits;
    logic [3:0][63:0] sbits;
    logic [223:0]     junk;
    logic             hs_p, vs_p;
    hbits = {bch({40'h0, hb}, 24), hb};
    for (int i = 0; i < 4; i++) begin
      sbits[i] = {bch({8'h0, pb[56*i +: 56]}, 56), pb[56*i +: 56]};
    end
    start            = 1'b1;
    pkt_if.PKT_VALID = 1'b1;
    pkt_if.PKT_HB    = hb;
    pkt_if.PKT_PB    = pb;
    if (rsync) begin
      hsync = 1'($urandom());
      vsync = 1'($urandom());
    end else begin
      hsync = 1'b1;
      vsync = 1'b0;
    end
    #1 check_eq("ready_accept", 32'(pkt_if.PKT_READY), 32'd1);
    for (int j = 1; j <= stop_j; j++) begin
      hs_p = hsync;
      vs_p = vsync;
      @(posedge clk);
      #1;
      check_eq($sformatf("island_j%0d", j), 32'(obs), 32'(exp_out(j, hbits, sbits, hs_p, vs_p)));
      start            = (poke && j < 45) ? 1'($urandom_range(0, 1)) : 1'b0;
      pkt_if.PKT_VALID = hold;
      pkt_if.PKT_HB    = 24'($urandom());
      rand_pb(junk);
      pkt_if.PKT_PB    = junk;
      if (rsync) begin
        hsync = 1'($urandom());
        vsync = 1'($urandom());
      end
      #1 check_eq($sformatf("ready_busy_j%0d", j), 32'(pkt_if.PKT_READY), 32'd0);
    end
  endtask

  initial begin
    logic [223:0] pb;
    logic [23:0]  hb;
    int  ade_n, first_n, rdy_n;
    bit  done;
    rst_n = 1'b0;
    start = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    pkt_if.PKT_VALID = 1'b0;
    pkt_if.PKT_HB    = '0;
    pkt_if.PKT_PB    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", 32'(obs), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_after_reset", 32'(obs), 32'd0);

    // Null packet with fixed sync levels.
    island(24'h0, 224'h0, 1'b0, 1'b0, 1'b0, 45);

    // START without PKT_VALID is ignored.
    start = 1'b1;
    pkt_if.PKT_VALID = 1'b0;
    #1 check_eq("ready_no_valid", 32'(pkt_if.PKT_READY), 32'd0);
    @(posedge clk);
    #1;
    check_eq("idle_no_valid", 32'(obs), 32'd0);
    start = 1'b0;

    // AVI header, random payload, stray STARTs while busy.
    rand_pb(pb);
    island(24'h0D0282, pb, HoldOk, 1'b1, 1'b1, 45);

    // Three islands with START 45 cycles apart.
    rand_pb(pb);
    hb = 24'($urandom());
    repeat (3) island(hb, pb, HoldOk, 1'b0, 1'b1, 45);

    // Reset during DATA k=10, then a full island right after.
    rand_pb(pb);
    island(24'($urandom()), pb, 1'b0, 1'b0, 1'b1, 21);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset_mid_island", 32'(obs), 32'd0);
    rst_n = 1'b1;
    rand_pb(pb);
    island(24'($urandom()), pb, 1'b0, 1'b0, 1'b1, 45);

    // PKT_VALID held high: packet count per island.
    rand_pb(pb);
    start            = 1'b1;
    pkt_if.PKT_VALID = 1'b1;
    pkt_if.PKT_HB    = 24'($urandom());
    pkt_if.PKT_PB    = pb;
    ade_n   = 0;
    first_n = 0;
    done    = 1'b0;
    #1 rdy_n = int'(pkt_if.PKT_READY);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 800 && !done; c++) begin
      if (ade) begin
        ade_n++;
        if (!aux0[3]) first_n++;
      end
      if (!busy) done = 1'b1;
      #1;
      if (pkt_if.PKT_READY) rdy_n++;
      @(posedge clk);
      #1;
    end
    pkt_if.PKT_VALID = 1'b0;
    check_eq("held_ade_cycles", 32'(ade_n), 32'(ExpPkts * 32));
    check_eq("held_first_cycles", 32'(first_n), 32'(ExpPkts));
    check_eq("held_ready_pulses", 32'(rdy_n), 32'(ExpPkts));
    check_eq("held_island_ended", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
